proc_ctrl: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit processor datapath (32 x 16-bit GPRs, SGPR, zero/sign/carry/overflow flags).
- Owns the program counter and instruction register.
- Fetches 32-bit instructions over a request/valid handshake.
- Issues one-cycle enables to the datapath; resolves conditional jumps from the registered flags.

---
 rtl/proc_pkg.sv | 69 ++++++
 rtl/proc_ctrl_if.sv | 14 +
 rtl/proc_ctrl_cond.sv | 32 +++
 rtl/proc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_proc_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor control sequencer: IR field positions,
// opcode values, sequencer state encoding and opcode classification helpers.
// Pure declarations; no logic, no latency, no flow control.
package proc_pkg;

    // Instruction register field positions
    localparam int OPER_MSB     = 31;
    localparam int OPER_LSB     = 27;
    localparam int RDST_MSB     = 26;
    localparam int RDST_LSB     = 22;
    localparam int RSRC1_MSB    = 21;
    localparam int RSRC1_LSB    = 17;
    localparam int IMM_MODE_BIT = 16;
    localparam int RSRC2_MSB    = 15;
    localparam int RSRC2_LSB    = 11;
    localparam int ISRC_MSB     = 15;
    localparam int ISRC_LSB     = 0;

    // Opcodes
    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;
    localparam logic [4:0] OP_JUMP    = 5'd16;
    localparam logic [4:0] OP_JCARRY  = 5'd17;
    localparam logic [4:0] OP_JNOCARRY= 5'd18;
    localparam logic [4:0] OP_JSIGN   = 5'd19;
    localparam logic [4:0] OP_JNOSIGN = 5'd20;
    localparam logic [4:0] OP_JZERO   = 5'd21;
    localparam logic [4:0] OP_JNOZERO = 5'd22;
    localparam logic [4:0] OP_JOVF    = 5'd23;
    localparam logic [4:0] OP_JNOVF   = 5'd24;
    localparam logic [4:0] OP_HALT    = 5'd31;

    // Sequencer states; STEPWAIT is only reachable in single-step builds
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_NEXT,
        ST_HALT,
        ST_STEPWAIT
    } state_t;

    // Opcodes 0..11 go through the datapath
    function automatic logic is_alu(input logic [4:0] op);
        return op <= OP_NOT;
    endfunction

    function automatic logic is_jump(input logic [4:0] op);
        return (op >= OP_JUMP) && (op <= OP_JNOVF);
    endfunction

    // MOV and MOVSGPR leave the flags alone
    function automatic logic sets_flags(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Instruction-memory fetch bus between the sequencer and instruction memory.
// No latency of its own; request is held until the memory returns valid.
// Backpressure: memory stalls the sequencer simply by withholding imem_valid.
interface proc_ctrl_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/proc_ctrl_cond.sv
// Jump condition resolver: opcode plus registered flags -> branch taken.
// Purely combinational, zero latency.
// No flow control; non-jump opcodes always resolve to not-taken.
module proc_ctrl_cond
    import proc_pkg::*;
(
    input  logic [4:0] op,
    input  logic       zero,
    input  logic       sign,
    input  logic       carry,
    input  logic       overflow,
    output logic       taken
);

    // Map each conditional jump to the flag (or its inverse) it tests
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JUMP:     taken = 1'b1;
            OP_JCARRY:   taken = carry;
            OP_JNOCARRY: taken = ~carry;
            OP_JSIGN:    taken = sign;
            OP_JNOSIGN:  taken = ~sign;
            OP_JZERO:    taken = zero;
            OP_JNOZERO:  taken = ~zero;
            OP_JOVF:     taken = overflow;
            OP_JNOVF:    taken = ~overflow;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_ctrl.sv
// Fetch/decode/execute/writeback sequencer owning pc and ir (PROC_CTRL_STEP_EN adds single-step).
// Latency: ALU op 4 + fetch cycles (MUL 3 + MUL_LAT + fetch), jump/illegal 2 + fetch cycles.
// Backpressure: imem_req held in FETCH until imem_valid; all outputs are registered.
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int MUL_LAT = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    proc_ctrl_if.master     imem,
    input  logic            zero,
    input  logic            sign,
    input  logic            carry,
    input  logic            overflow,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            alu_en,
    output logic            gpr_we,
    output logic            sgpr_we,
    output logic            flag_we,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t           state;
    logic             taken;
    logic             cond_taken;
    logic             imem_req_q;
    logic [CNT_W-1:0] exec_cnt;
    logic [4:0]       op;

    assign op             = ir[OPER_MSB:OPER_LSB];
    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc;

`ifndef PROC_CTRL_STEP_EN
    // Without single-step the step input has no function
    logic unused_step;
    assign unused_step = step;
`endif

    proc_ctrl_cond u_cond (
        .op       (op),
        .zero     (zero),
        .sign     (sign),
        .carry    (carry),
        .overflow (overflow),
        .taken    (cond_taken)
    );

    // Sequencer FSM; every output is set on the transition into the state that owns it
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= '0;
            ir         <= '0;
            imem_req_q <= 1'b0;
            alu_en     <= 1'b0;
            gpr_we     <= 1'b0;
            sgpr_we    <= 1'b0;
            flag_we    <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            taken      <= 1'b0;
            exec_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_FETCH;
                        imem_req_q <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        ir         <= imem.imem_rdata;
                        imem_req_q <= 1'b0;
                        state      <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_alu(op)) begin
                        state    <= ST_EXECUTE;
                        alu_en   <= 1'b1;
                        exec_cnt <= (op == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
                    end else if (is_jump(op)) begin
                        // flags are sampled here, not in NEXT
                        state <= ST_NEXT;
                        taken <= cond_taken;
                    end else if (op == OP_HALT) begin
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        // undefined opcode behaves as a NOP but is remembered
                        state   <= ST_NEXT;
                        taken   <= 1'b0;
                        illegal <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (exec_cnt == '0) begin
                        state   <= ST_WRITEBACK;
                        alu_en  <= 1'b0;
                        gpr_we  <= 1'b1;
                        sgpr_we <= (op == OP_MUL);
                        flag_we <= sets_flags(op);
                    end else begin
                        exec_cnt <= exec_cnt - 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    state   <= ST_NEXT;
                    gpr_we  <= 1'b0;
                    sgpr_we <= 1'b0;
                    flag_we <= 1'b0;
                end
                ST_NEXT: begin
                    pc    <= taken ? ir[PC_W-1:0] : pc + 1'b1;
                    taken <= 1'b0;
`ifdef PROC_CTRL_STEP_EN
                    state <= ST_STEPWAIT;
`else
                    state      <= ST_FETCH;
                    imem_req_q <= 1'b1;
`endif
                end
`ifdef PROC_CTRL_STEP_EN
                ST_STEPWAIT: begin
                    if (step) begin
                        state      <= ST_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
`endif
                ST_HALT: begin
                    // pc still points at the HALT word; resume just past it
                    if (start) begin
                        pc         <= pc + 1'b1;
                        state      <= ST_FETCH;
                        imem_req_q <= 1'b1;
                        busy       <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    imem_req_q <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed vector table, hand-built halt/reset
// sequences and randomized instructions checked against an instruction-level model.
// Flags are held stable for the whole life of each instruction.
module tb_proc_ctrl;

    localparam int PC_W    = 8;
    localparam int MUL_LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        step  = 1'b0;
    logic        zero = 1'b0, sign = 1'b0, carry = 1'b0, overflow = 1'b0;
    logic [31:0] ir;
    logic [PC_W-1:0] pc;
    logic        alu_en, gpr_we, sgpr_we, flag_we, busy, halted, illegal;

    proc_ctrl_if #(.PC_W(PC_W)) imem_bus ();

    proc_ctrl #(.PC_W(PC_W), .MUL_LAT(MUL_LAT)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .step     (step),
        .imem     (imem_bus),
        .zero     (zero),
        .sign     (sign),
        .carry    (carry),
        .overflow (overflow),
        .ir       (ir),
        .pc       (pc),
        .alu_en   (alu_en),
        .gpr_we   (gpr_we),
        .sgpr_we  (sgpr_we),
        .flag_we  (flag_we),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  flg;     // {zero, sign, carry, overflow}
        int          dly;
        int          e_alu;
        int          e_gpr;
        int          e_sgpr;
        int          e_flag;
        int          e_lat;
        int          e_next;
        int          e_ill;
        int          e_halt;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] irv;
        int          alu, gpr, sgpr, flg, lat, stray, nxt;
        int          hlt, ill, to;
    } obs_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input int op, input int rd, input int rs1,
                                        input int imm, input int isrc);
        logic [31:0] w;
        w = '0;
        w[31:27] = op[4:0];
        w[26:22] = rd[4:0];
        w[21:17] = rs1[4:0];
        w[16]    = imm[0];
        w[15:0]  = isrc[15:0];
        return w;
    endfunction

    function automatic vec_t mkv(input logic [31:0] w, input logic [3:0] f, input int dly,
                                 input int a, input int g, input int s, input int fl,
                                 input int lat, input int nx, input int il, input int h);
        vec_t v;
        v.word = w; v.flg = f; v.dly = dly;
        v.e_alu = a; v.e_gpr = g; v.e_sgpr = s; v.e_flag = fl;
        v.e_lat = lat; v.e_next = nx; v.e_ill = il; v.e_halt = h;
        return v;
    endfunction

    // Instruction-level reference: what one instruction should do, from the ISA rules
    function automatic vec_t model(input logic [31:0] w, input logic [3:0] f, input int dly,
                                   input int pcv, input int ill_in);
        vec_t v;
        int   op;
        logic z, s, c, o;
        logic tk;
        logic tab [9];
        op = int'(w[31:27]);
        {z, s, c, o} = f;
        tab = '{1'b1, c, !c, s, !s, z, !z, o, !o};
        v.word = w; v.flg = f; v.dly = dly;
        v.e_alu = 0; v.e_gpr = 0; v.e_sgpr = 0; v.e_flag = 0;
        v.e_halt = 0; v.e_ill = ill_in;
        tk = 1'b0;
        if (op <= 11) begin
            v.e_alu  = (op == 4) ? MUL_LAT : 1;
            v.e_gpr  = 1;
            v.e_sgpr = (op == 4) ? 1 : 0;
            v.e_flag = (op >= 2) ? 1 : 0;
            v.e_lat  = 3 + v.e_alu;
        end else if (op == 31) begin
            v.e_halt = 1;
            v.e_lat  = 1;
        end else begin
            v.e_lat = 2;
            if (op >= 16 && op <= 24) tk = tab[op - 16];
            else v.e_ill = 1;
        end
        if (v.e_halt != 0)  v.e_next = pcv;
        else if (tk)        v.e_next = int'(w[7:0]);
        else                v.e_next = (pcv + 1) % 256;
        return v;
    endfunction

    // Serve one fetch with the given word/delay and observe the instruction's life
    task automatic run_instr(input logic [31:0] w, input logic [3:0] f, input int dly,
                             output obs_t o);
        int n;
        o = '{default: 0};
        n = 0;
        while (!imem_bus.imem_req && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!imem_bus.imem_req) begin
            o.to = 1;
            return;
        end
        o.addr = int'(imem_bus.imem_addr);
        {zero, sign, carry, overflow} = f;
        for (int k = 0; k < dly; k++) begin
            imem_bus.imem_valid = 1'b0;
            imem_bus.imem_rdata = $urandom;
            @(negedge clock);
        end
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = w;
        @(negedge clock);
        imem_bus.imem_valid = 1'b0;
        o.irv = ir;
        n = 0;
        while (!imem_bus.imem_req && !halted && n < 60) begin
            o.alu  += int'(alu_en);
            o.gpr  += int'(gpr_we);
            o.sgpr += int'(sgpr_we);
            o.flg  += int'(flag_we);
            if ((sgpr_we && !gpr_we) || (flag_we && !gpr_we) || (alu_en && gpr_we))
                o.stray++;
            o.lat++;
            n++;
            @(negedge clock);
        end
        if (n >= 60) o.to = 1;
        o.nxt = int'(imem_bus.imem_addr);
        o.hlt = int'(halted);
        o.ill = int'(illegal);
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o, input int exp_addr);
        chk({tag, ".timeout"}, o.to, 0);
        chk({tag, ".addr"},    o.addr, exp_addr);
        chk({tag, ".ir"},      int'(o.irv == v.word), 1);
        chk({tag, ".alu_en"},  o.alu, v.e_alu);
        chk({tag, ".gpr_we"},  o.gpr, v.e_gpr);
        chk({tag, ".sgpr_we"}, o.sgpr, v.e_sgpr);
        chk({tag, ".flag_we"}, o.flg, v.e_flag);
        chk({tag, ".stray"},   o.stray, 0);
        chk({tag, ".latency"}, o.lat, v.e_lat);
        chk({tag, ".next_pc"}, o.nxt, v.e_next);
        chk({tag, ".illegal"}, o.ill, v.e_ill);
        chk({tag, ".halted"},  o.hlt, v.e_halt);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    vec_t tbl [12];
    obs_t ob;
    vec_t ev;
    int   exp_addr;
    int   ill_m;
    int   cnt;

    initial begin
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_rdata = '0;

        // op, rdst, rsrc1, imm, isrc / flags {z,s,c,o} / dly / alu gpr sgpr flag lat next ill halt
        tbl[0]  = mkv(mkw(2, 0, 2, 1, 5),      4'b0000, 1, 1, 1, 0, 1, 4, 8'h01, 0, 0); // ADDI
        tbl[1]  = mkv(mkw(4, 3, 1, 0, 2<<11),  4'b0000, 0, 2, 1, 1, 1, 5, 8'h02, 0, 0); // MUL
        tbl[2]  = mkv(mkw(1, 4, 0, 1, 16'h77), 4'b0000, 2, 1, 1, 0, 0, 4, 8'h03, 0, 0); // MOV
        tbl[3]  = mkv(mkw(21, 0, 0, 1, 8'h20), 4'b1000, 0, 0, 0, 0, 0, 2, 8'h20, 0, 0); // JZERO taken
        tbl[4]  = mkv(mkw(21, 0, 0, 1, 8'h40), 4'b0111, 1, 0, 0, 0, 0, 2, 8'h21, 0, 0); // JZERO not taken
        tbl[5]  = mkv(mkw(18, 0, 0, 1, 8'h50), 4'b0010, 0, 0, 0, 0, 0, 2, 8'h22, 0, 0); // JNOCARRY c=1
        tbl[6]  = mkv(mkw(13, 0, 0, 0, 8'h60), 4'b1111, 0, 0, 0, 0, 0, 2, 8'h23, 1, 0); // illegal
        tbl[7]  = mkv(mkw(16, 0, 0, 1, 8'hFF), 4'b0000, 1, 0, 0, 0, 0, 2, 8'hFF, 1, 0); // JUMP
        tbl[8]  = mkv(mkw(2, 1, 1, 0, 2<<11),  4'b0000, 0, 1, 1, 0, 1, 4, 8'h00, 1, 0); // ADD wraps pc
        tbl[9]  = mkv(mkw(11, 2, 3, 0, 0),     4'b0000, 2, 1, 1, 0, 1, 4, 8'h01, 1, 0); // NOT
        tbl[10] = mkv(mkw(19, 0, 0, 1, 8'h05), 4'b0100, 0, 0, 0, 0, 0, 2, 8'h05, 1, 0); // JSIGN taken
        tbl[11] = mkv(mkw(31, 0, 0, 0, 0),     4'b0000, 1, 0, 0, 0, 0, 1, 8'h05, 1, 1); // HALT at 5

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset.pc", int'(pc), 0);
        chk("reset.ir", int'(ir != 0), 0);
        chk("reset.ctl", int'({imem_bus.imem_req, alu_en, gpr_we, sgpr_we, flag_we,
                               busy, halted, illegal}), 0);
        repeat (2) @(negedge clock);
        chk("idle.no_req", int'(imem_bus.imem_req), 0);

        // Directed vector table, one instruction after another from pc 0
        pulse_start();
        exp_addr = 0;
        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].word, tbl[i].flg, tbl[i].dly, ob);
            compare($sformatf("vec%0d", i), tbl[i], ob, exp_addr);
            exp_addr = tbl[i].e_next;
        end

        // Halted: stays put, no fetches, then resumes just past the HALT word
        chk("halt.pc", int'(pc), 5);
        chk("halt.busy", int'(busy), 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            cnt += int'(imem_bus.imem_req);
        end
        chk("halt.req_cycles", cnt, 0);
        chk("halt.still_halted", int'(halted), 1);
        pulse_start();
        chk("resume.req", int'(imem_bus.imem_req), 1);
        chk("resume.addr", int'(imem_bus.imem_addr), 6);
        chk("resume.halted", int'(halted), 0);

        // Reset during MUL execute with a pending valid on the bus
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_rdata = mkw(4, 1, 2, 0, 3<<11);
        @(negedge clock);
        imem_bus.imem_valid = 1'b0;
        @(negedge clock);
        chk("rstmid.alu_en", int'(alu_en), 1);
        reset = 1'b1;
        imem_bus.imem_valid = 1'b1;
        @(negedge clock);
        chk("rstmid.pc", int'(pc), 0);
        chk("rstmid.ir", int'(ir != 0), 0);
        chk("rstmid.ctl", int'({imem_bus.imem_req, alu_en, gpr_we, sgpr_we, flag_we,
                                busy, halted, illegal}), 0);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            cnt += int'(imem_bus.imem_req) + int'(busy);
        end
        chk("rstmid.idle", cnt, 0);
        imem_bus.imem_valid = 1'b0;

        // Randomized instruction stream against the reference model
        pulse_start();
        exp_addr = 0;
        ill_m    = 0;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] w;
            logic [3:0]  f;
            int          d;
            w = $urandom;
            if ($urandom_range(0, 9) == 0) w[31:27] = 5'd31;
            f = 4'($urandom_range(0, 15));
            d = $urandom_range(0, 2);
            ev = model(w, f, d, exp_addr, ill_m);
            run_instr(w, f, d, ob);
            compare($sformatf("rnd%0d", i), ev, ob, exp_addr);
            ill_m    = ev.e_ill;
            exp_addr = ev.e_next;
            if (ev.e_halt != 0) begin
                pulse_start();
                exp_addr = (exp_addr + 1) % 256;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
